prog_mem_loader: RTL and testbench

//  Write-side counterpart of the program ROM: accepts a framed byte stream (from a UART/debug

---
 rtl/prog_mem_loader.sv | 150 +++++++++++++++
 tb/tb_prog_mem_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Framed byte-stream loader for program memory: parses sync/address/count/data/checksum,
// writes assembled instruction words at auto-incrementing addresses and stalls the core meanwhile.
module prog_mem_loader #(
  parameter int INST_WIDTH = 12,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int AHW = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 8 : 1;
  localparam int DHW = INST_WIDTH - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L, S_CSUM
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [AHW-1:0]        r_addr_h;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cnt_h;
  logic [15:0]           r_cnt;
  logic [DHW-1:0]        r_data_h;
  logic [INST_WIDTH-1:0] r_wdata;
  logic [7:0]            r_sum;
  logic [TW-1:0]         r_tmo;
  logic                  r_we, r_hold, r_done, r_err;

  logic                  w_xfer, w_sync, w_csum_chk, w_sum_en, w_wr, w_tmo_hit;
  logic [15:0]           w_cnt_ld;
  logic [ADDR_WIDTH-1:0] w_addr_ld;
  logic [INST_WIDTH-1:0] w_word;

  // No backpressure: every valid byte is a transfer.
  assign rx_ready  = 1'b1;
  assign w_xfer    = rx_valid;
  assign w_sync    = w_xfer && (r_state == S_IDLE) && (rx_data == 8'hA5);
  assign w_csum_chk = w_xfer && (r_state == S_CSUM);
  assign w_sum_en  = w_xfer && (r_state != S_IDLE) && (r_state != S_CSUM);
  assign w_wr      = w_xfer && (r_state == S_DATA_L);
  assign w_tmo_hit = (r_state != S_IDLE) && !w_xfer && (r_tmo == TW'(TIMEOUT - 1));
  assign w_cnt_ld  = {r_cnt_h, rx_data};
  assign w_word    = {r_data_h, rx_data};

  generate
    if (ADDR_WIDTH > 8) begin : g_addr_wide
      assign w_addr_ld = {r_addr_h, rx_data};
    end else begin : g_addr_narrow
      assign w_addr_ld = rx_data[ADDR_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE:   if (rx_data == 8'hA5) w_state_nxt = S_ADDR_H;
        S_ADDR_H: w_state_nxt = S_ADDR_L;
        S_ADDR_L: w_state_nxt = S_CNT_H;
        S_CNT_H:  w_state_nxt = S_CNT_L;
        S_CNT_L:  w_state_nxt = (w_cnt_ld == 16'd0) ? S_CSUM : S_DATA_H;
        S_DATA_H: w_state_nxt = S_DATA_L;
        S_DATA_L: w_state_nxt = (r_cnt == 16'd1) ? S_CSUM : S_DATA_H;
        S_CSUM:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_h <= '0;
      r_addr   <= '0;
      r_cnt_h  <= '0;
      r_cnt    <= '0;
      r_data_h <= '0;
      r_wdata  <= '0;
      r_sum    <= '0;
      r_tmo    <= '0;
      r_we     <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we   <= w_wr;
      r_done <= w_csum_chk && (r_sum == rx_data);

      // Post-write increment; an address load can never coincide with a pending write.
      if (r_we) r_addr <= r_addr + 1'b1;

      if (w_xfer) begin
        case (r_state)
          S_ADDR_H: r_addr_h <= rx_data[AHW-1:0];
          S_ADDR_L: r_addr   <= w_addr_ld;
          S_CNT_H:  r_cnt_h  <= rx_data;
          S_CNT_L:  r_cnt    <= w_cnt_ld;
          S_DATA_H: r_data_h <= rx_data[DHW-1:0];
          S_DATA_L: begin
            r_wdata <= w_word;
            r_cnt   <= r_cnt - 16'd1;
          end
          default: ;
        endcase
      end

      if (w_sync)        r_sum <= 8'd0;
      else if (w_sum_en) r_sum <= r_sum + rx_data;

      if ((r_state == S_IDLE) || w_xfer || w_tmo_hit) r_tmo <= '0;
      else                                           r_tmo <= r_tmo + 1'b1;

      if (w_sync) begin
        r_err  <= 1'b0;
        r_hold <= 1'b1;
      end else if (w_csum_chk) begin
        r_hold <= 1'b0;
        if (r_sum != rx_data) r_err <= 1'b1;
      end else if (w_tmo_hit) begin
        r_hold <= 1'b0;
        r_err  <= 1'b1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign core_hold = r_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: byte-level frames, write log from a negedge monitor,
// immediate-assertion checks against hand-computed values.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, core_hold, done, err;
  logic [8:0]  mem_addr;
  logic [11:0] mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [8:0]  wa[$];
  logic [11:0] wd[$];

  prog_mem_loader #(.INST_WIDTH(12), .ADDR_WIDTH(9), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_ready", rx_ready, 1);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold",  core_hold, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: checksum 10+02+0A+BC+01+23 = 0xFC
    clr_log();
    send(8'hA5);
    chk("t1_hold_sync", core_hold, 1);
    send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h0A); send(8'hBC); send(8'h01); send(8'h23);
    chk("t1_hold_mid", core_hold, 1);
    send(8'hFC);
    chk("t1_done", done, 1);
    chk("t1_hold_drop", core_hold, 0);
    chk("t1_err", err, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("t1_a0", wa[0], 9'h010); chk("t1_d0", wd[0], 12'hABC);
      chk("t1_a1", wa[1], 9'h011); chk("t1_d1", wd[1], 12'h123);
    end

    // T2: bad checksum, writes still land
    clr_log();
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h0A); send(8'hBC); send(8'h01); send(8'h23); send(8'h00);
    chk("t2_err", err, 1);
    chk("t2_hold", core_hold, 0);
    @(posedge clk); #1;
    chk("t2_err_sticky", err, 1);
    chk("t2_ndone", done_cnt, 0);
    chk("t2_nwr", wa.size(), 2);

    // T3: wrap 1FF->000; DATA_H upper nibble ignored. csum 01+FF+02+F0+11+22 = 0x25
    clr_log();
    send(8'hA5);
    chk("t3_err_clr", err, 0);
    send(8'h01); send(8'hFF); send(8'h00); send(8'h02);
    send(8'hF0); send(8'h11); send(8'h00); send(8'h22); send(8'h25);
    chk("t3_done", done, 1);
    @(posedge clk); #1;
    chk("t3_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("t3_a0", wa[0], 9'h1FF); chk("t3_d0", wd[0], 12'h011);
      chk("t3_a1", wa[1], 9'h000); chk("t3_d1", wd[1], 12'h022);
    end

    // T4: zero-count frame
    clr_log();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    chk("t4_done", done, 1);
    chk("t4_err", err, 0);
    @(posedge clk); #1;
    chk("t4_nwr", wa.size(), 0);

    // T5: stall after DATA_H; abort on the TIMEOUT-th idle edge
    clr_log();
    send(8'hA5); send(8'h00); send(8'h20); send(8'h00); send(8'h01); send(8'h0F);
    repeat (1023) @(posedge clk);
    #1;
    chk("t5_err_early", err, 0);
    chk("t5_hold_early", core_hold, 1);
    @(posedge clk); #1;
    chk("t5_err", err, 1);
    chk("t5_hold", core_hold, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_nwr", wa.size(), 0);
    // recovery: csum 20+01+0F+ED = 0x1D
    send(8'hA5);
    chk("t5_err_clr", err, 0);
    send(8'h00); send(8'h20); send(8'h00); send(8'h01); send(8'h0F); send(8'hED);
    send(8'h1D);
    chk("t5_done", done, 1);
    @(posedge clk); #1;
    chk("t5_nwr2", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t5_a0", wa[0], 9'h020); chk("t5_d0", wd[0], 12'hFED);
    end

    // T6: junk ignored, reset mid-frame, then a frame carrying A5 as data
    clr_log();
    send(8'h11); send(8'h22);
    chk("t6_junk_hold", core_hold, 0);
    send(8'hA5); send(8'h00); send(8'h30); send(8'h00); send(8'h01); send(8'hAB);
    chk("t6_hold_pre", core_hold, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_hold", core_hold, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // csum 05+01+01+A5 = 0xAC
    send(8'hA5); send(8'h00); send(8'h05); send(8'h00); send(8'h01);
    send(8'h01); send(8'hA5); send(8'hAC);
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    @(posedge clk); #1;
    chk("t6_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t6_a0", wa[0], 9'h005); chk("t6_d0", wd[0], 12'h1A5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
